seq_divider: RTL and testbench
==============================

Name: seq_divider

Overview:
- Multi-cycle radix-2 restoring divider. It is the responder side of the start/busy/over handshake that the MDU issues for DIV/DIVU.
- One instance serves both signed and unsigned division, selected per operation by is_signed.
- Operands are latched at start. Quotient and remainder are held stable after completion until the next accepted start, so the pipeline stall logic can sample them when `over` is asserted.

Parameters:
WIDTH, 32, operand/quotient/remainder width in bits (must be >= 2)
CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden)

Ports:
clk  input  1  rising-edge clock
rst  input  1  reset rst, synchronous, active-high; also the abort path used by the MDU
start  input  1  request; accepted only on a clock edge where busy=0
is_signed  input  1  1 = two's-complement divide, 0 = unsigned; sampled with start
dividend  input  WIDTH  numerator; sampled with start
divisor  input  WIDTH  denominator; sampled with start
q  output  WIDTH  quotient, registered
r  output  WIDTH  remainder, registered
busy  output  1  high while iterating
over  output  1  one-cycle completion pulse
div_zero  output  1  divisor was zero for the operation just completed; held with q/r

Behaviour:
- Reset (rst=1 at a clock edge): state=IDLE, busy=0, over=0, div_zero=0, q=0, r=0, counter=0.
  - Reset mid-operation discards the partial result. The next cycle is IDLE with no over pulse.
  - rst has priority over start.
- States:
  - IDLE: busy=0. start=1 latches the operands, is_signed, and the sign flags, then goes to RUN.
    - Latched operand = absolute value when is_signed, raw value otherwise.
    - On entry to RUN: counter=WIDTH, partial remainder=0, busy=1, over=0.
  - RUN: one iteration per clock.
    - Shift {rem,quo} left 1. Trial = rem_shifted - divisor_mag (WIDTH+1 bits).
    - If trial is non-negative: rem=trial[WIDTH-1:0] and quo LSB=1. Otherwise quo LSB=0.
    - Decrement counter. On the edge where counter goes 1->0, go to DONE.
  - DONE: a registered transition, not an extra cycle of busy. It is the same edge as the last iteration.
    - q/r are loaded with the sign-corrected results. busy=0. over=1 for exactly one cycle. Then back to IDLE behaviour.
- Latency:
  - start sampled at edge E0; busy=1 from E0 to E32 (WIDTH edges of RUN).
  - busy falls at E32. over=1 during the cycle after E32, i.e. WIDTH+1 edges from start to the over cycle.
- Handshake:
  - start while busy=1 is ignored; operands are not re-sampled.
  - start in the over cycle is accepted (busy=0). Back-to-back operations are therefore legal; over drops at the next edge while busy rises.
  - Holding start high continuously restarts immediately after every completion.
- q, r, div_zero:
  - Change only at completion or reset.
  - Hold their value through IDLE and through the next RUN until that RUN completes.
- Sign rules (is_signed=1):
  - Quotient truncates toward zero: q negative iff sign(dividend) XOR sign(divisor) and q != 0.
  - Remainder takes the sign of the dividend.
  - Absolute value of -2^(WIDTH-1) is taken as the unsigned value 2^(WIDTH-1).
  - Overflow case -2^31 / -1: q=0x80000000, r=0, no flag.
- Divide by zero (any mode):
  - Full WIDTH-cycle latency is still taken.
  - Result is q=all ones and r=raw latched dividend, overriding sign correction. div_zero=1.
- Unsigned mode: no sign correction. Operands are full WIDTH-bit unsigned values.

Test Plan:
- Unsigned 100/7, is_signed=0 -> busy high 32 cycles, over single pulse at cycle 33, q=14, r=2, div_zero=0.
- Signed -7/2 (0xFFFFFFF9 / 2) -> q=0xFFFFFFFD, r=0xFFFFFFFF. Also check 7/-2 -> q=0xFFFFFFFD, r=1; and -7/-2 -> q=3, r=0xFFFFFFFF.
- Edge values: signed 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0. Unsigned 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0. Unsigned 5/9 -> q=0, r=5.
- Divide by zero: signed 0xFFFFFFF0/0 -> after 33 edges q=0xFFFFFFFF, r=0xFFFFFFF0, div_zero=1. A following 10/3 clears div_zero and gives q=3, r=1.
- Handshake: start pulsed again at cycles 5 and 20 with different operands -> ignored, result matches the first operands. New start in the over cycle -> accepted, busy=1 next cycle, second result correct after another 32 cycles.
- Abort: rst=1 at cycle 10 of RUN -> next cycle busy=0, over never pulses, q=r=0. A fresh start afterwards completes normally.

Source files
------------

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider (signed/unsigned) answering the MDU
// start/busy/over handshake; q, r and div_zero hold until the next completion.
module seq_divider #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             over,
  output logic             div_zero
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [WIDTH-1:0] rem, rem_n;
  logic [WIDTH-1:0] quo, quo_n;
  logic [WIDTH-1:0] dvsr, dvsr_n;   // divisor magnitude
  logic [WIDTH-1:0] dvd, dvd_n;     // raw dividend, returned as r on divide by zero
  logic             neg_q, neg_q_n;
  logic             neg_r, neg_r_n;
  logic [WIDTH-1:0] q_n, r_n;
  logic             over_n, div_zero_n;

  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_step, quo_step;

  assign busy = (state == RUN);

  // One restoring step: shift {rem,quo} left and try to subtract the divisor.
  always_comb begin
    trial = {rem, quo[WIDTH-1]} - {1'b0, dvsr};
    if (!trial[WIDTH]) begin
      rem_step = trial[WIDTH-1:0];
      quo_step = {quo[WIDTH-2:0], 1'b1};
    end else begin
      rem_step = {rem[WIDTH-2:0], quo[WIDTH-1]};
      quo_step = {quo[WIDTH-2:0], 1'b0};
    end
  end

  always_comb begin
    // NOTE: every signal is defaulted first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_n    = state;
    cnt_n      = cnt;
    rem_n      = rem;
    quo_n      = quo;
    dvsr_n     = dvsr;
    dvd_n      = dvd;
    neg_q_n    = neg_q;
    neg_r_n    = neg_r;
    q_n        = q;
    r_n        = r;
    div_zero_n = div_zero;
    over_n     = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          cnt_n   = CNT_INIT;
          rem_n   = '0;
          quo_n   = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
          dvsr_n  = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
          dvd_n   = dividend;
          neg_q_n = is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          neg_r_n = is_signed && dividend[WIDTH-1];
        end
      end
      RUN: begin
        rem_n = rem_step;
        quo_n = quo_step;
        cnt_n = cnt - CNT_ONE;
        if (cnt == CNT_ONE) begin
          state_n = IDLE;
          over_n  = 1'b1;
          if (dvsr == '0) begin
            q_n        = '1;
            r_n        = dvd;
            div_zero_n = 1'b1;
          end else begin
            q_n        = neg_q ? -quo_step : quo_step;
            r_n        = neg_r ? -rem_step : rem_step;
            div_zero_n = 1'b0;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      dvd      <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      q        <= '0;
      r        <= '0;
      over     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      rem      <= rem_n;
      quo      <= quo_n;
      dvsr     <= dvsr_n;
      dvd      <= dvd_n;
      neg_q    <= neg_q_n;
      neg_r    <= neg_r_n;
      q        <= q_n;
      r        <= r_n;
      over     <= over_n;
      div_zero <= div_zero_n;
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider: latency, signed/unsigned
// results, divide by zero, ignored/back-to-back starts and abort via rst.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic [31:0] q;
  logic [31:0] r;
  logic        busy;
  logic        over;
  logic        div_zero;

  int checks   = 0;
  int failures = 0;
  int busy_hi;

  typedef struct {
    logic        sgn;
    logic [31:0] a, b, q, r;
  } vec_t;

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .q(q), .r(r),
    .busy(busy), .over(over), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Issues one start and waits (bounded) for over; edges counts from the
  // accepting edge inclusive, so the over cycle is reached at edges == 33.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output int edges);
    @(negedge clk);
    start = 1'b1; is_signed = sgn; dividend = a; divisor = b;
    @(negedge clk);
    start   = 1'b0;
    edges   = 1;
    busy_hi = busy ? 1 : 0;
    while (!over && edges < 100) begin
      @(negedge clk);
      edges++;
      if (busy) busy_hi++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, over, div_zero} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b exp=000", {busy, over, div_zero});
    end
    checks++;
    if (q !== 32'h0 || r !== 32'h0) begin
      failures++; $display("FAIL reset_qr got q=%h r=%h exp q=0 r=0", q, r);
    end
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int edges;
    do_div(1'b0, 32'd100, 32'd7, edges);
    checks++;
    if (edges !== 33) begin
      failures++; $display("FAIL unsigned_latency got=%0d exp=33", edges);
    end
    checks++;
    if (busy_hi !== 32) begin
      failures++; $display("FAIL unsigned_busy_cycles got=%0d exp=32", busy_hi);
    end
    checks++;
    if (q !== 32'd14 || r !== 32'd2 || div_zero !== 1'b0) begin
      failures++; $display("FAIL unsigned_100_7 got q=%h r=%h dz=%b exp q=e r=2 dz=0", q, r, div_zero);
    end
    @(negedge clk);
    checks++;
    if (over !== 1'b0 || q !== 32'd14) begin
      failures++; $display("FAIL over_single_pulse got over=%b q=%h exp over=0 q=e", over, q);
    end
  endtask

  task automatic test_vectors();
    vec_t vecs[6];
    int   edges;
    vecs[0] = '{1'b1, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 32'hFFFF_FFFF};
    vecs[1] = '{1'b1, 32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1};
    vecs[2] = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF};
    vecs[3] = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
    vecs[4] = '{1'b0, 32'hFFFF_FFFF, 32'd1,        32'hFFFF_FFFF, 32'd0};
    vecs[5] = '{1'b0, 32'd5,         32'd9,        32'd0,         32'd5};
    for (int i = 0; i < 6; i++) begin
      do_div(vecs[i].sgn, vecs[i].a, vecs[i].b, edges);
      checks++;
      if (edges !== 33 || q !== vecs[i].q || r !== vecs[i].r || div_zero !== 1'b0) begin
        failures++;
        $display("FAIL vector_%0d got edges=%0d q=%h r=%h dz=%b exp edges=33 q=%h r=%h dz=0",
                 i, edges, q, r, div_zero, vecs[i].q, vecs[i].r);
      end
    end
  endtask

  task automatic test_div_zero();
    int edges;
    do_div(1'b1, 32'hFFFF_FFF0, 32'd0, edges);
    checks++;
    if (edges !== 33 || q !== 32'hFFFF_FFFF || r !== 32'hFFFF_FFF0 || div_zero !== 1'b1) begin
      failures++;
      $display("FAIL div_zero got edges=%0d q=%h r=%h dz=%b exp edges=33 q=ffffffff r=fffffff0 dz=1",
               edges, q, r, div_zero);
    end
    do_div(1'b0, 32'd10, 32'd3, edges);
    checks++;
    if (edges !== 33 || q !== 32'd3 || r !== 32'd1 || div_zero !== 1'b0) begin
      failures++;
      $display("FAIL after_div_zero got edges=%0d q=%h r=%h dz=%b exp edges=33 q=3 r=1 dz=0",
               edges, q, r, div_zero);
    end
  endtask

  task automatic test_back_to_back();
    int edges;
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd9;
    @(negedge clk);
    start = 1'b0;
    edges = 1;
    while (!over && edges < 100) begin
      if (edges == 5 || edges == 20) begin
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
      end
      @(negedge clk);
      start = 1'b0;
      edges++;
      if (edges == 10) begin
        checks++;
        if (q !== 32'd3 || r !== 32'd1 || div_zero !== 1'b0) begin
          failures++; $display("FAIL hold_during_run got q=%h r=%h dz=%b exp q=3 r=1 dz=0", q, r, div_zero);
        end
      end
    end
    checks++;
    if (edges !== 33 || q !== 32'd111 || r !== 32'd1) begin
      failures++; $display("FAIL ignored_start got edges=%0d q=%h r=%h exp edges=33 q=6f r=1", edges, q, r);
    end
    // Start issued in the over cycle must be accepted.
    start = 1'b1; dividend = 32'd77; divisor = 32'd10;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || over !== 1'b0) begin
      failures++; $display("FAIL over_cycle_start got busy=%b over=%b exp busy=1 over=0", busy, over);
    end
    edges = 1;
    while (!over && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    checks++;
    if (edges !== 33 || q !== 32'd7 || r !== 32'd7) begin
      failures++; $display("FAIL back_to_back got edges=%0d q=%h r=%h exp edges=33 q=7 r=7", edges, q, r);
    end
  endtask

  task automatic test_abort();
    int edges;
    int over_seen = 0;
    @(negedge clk);
    start = 1'b1; is_signed = 1'b0; dividend = 32'd1000; divisor = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (busy !== 1'b0 || q !== 32'h0 || r !== 32'h0 || div_zero !== 1'b0) begin
      failures++; $display("FAIL abort_state got busy=%b q=%h r=%h dz=%b exp all 0", busy, q, r, div_zero);
    end
    repeat (40) begin
      if (over) over_seen++;
      @(negedge clk);
    end
    checks++;
    if (over_seen !== 0) begin
      failures++; $display("FAIL abort_no_over got over_cycles=%0d exp=0", over_seen);
    end
    do_div(1'b0, 32'd255, 32'd16, edges);
    checks++;
    if (edges !== 33 || q !== 32'd15 || r !== 32'd15) begin
      failures++; $display("FAIL after_abort got edges=%0d q=%h r=%h exp edges=33 q=f r=f", edges, q, r);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_vectors();
    test_div_zero();
    test_back_to_back();
    test_abort();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
